// File: rtl/hazard_if.sv
// Pipeline hazard control bus: ID/EX hazard inputs in, stall/flush controls out.
// The slave side is the hazard controller; the master side is the pipeline.
interface hazard_if;
  logic [2:0] ifidA;
  logic [2:0] ifidB;
  logic       useA;
  logic       useB;
  logic       idexR;
  logic [2:0] idexD;
  logic       idexMD;
  logic       exTaken;
  logic       stall;
  logic       flushIfid;
  logic       flushIdex;
  logic       mdBusy;
  logic [7:0] stallCnt;

  modport master (
    output ifidA, ifidB, useA, useB, idexR, idexD, idexMD, exTaken,
    input  stall, flushIfid, flushIdex, mdBusy, stallCnt
  );

  modport slave (
    input  ifidA, ifidB, useA, useB, idexR, idexD, idexMD, exTaken,
    output stall, flushIfid, flushIdex, mdBusy, stallCnt
  );
endinterface

// File: rtl/hazard_ctl.sv
// Hazard controller: load-use stalls, multi-cycle EX occupancy and branch flushes,
// plus a saturating count of stalled cycles.
module hazard_ctl #(
  parameter int MD_LAT = 4
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MDBUSY = 2'd1;
  localparam logic [1:0] FLUSH2 = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic stall_c, flush_ifid_c, flush_idex_c, md_busy_c;

  assign lu = bus.idexR & ((bus.useA & (bus.ifidA == bus.idexD)) |
                           (bus.useB & (bus.ifidB == bus.idexD)));

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    stall_c      = 1'b0;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;
    md_busy_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.exTaken) begin
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          state_d      = FLUSH2;
        end else if (bus.idexMD) begin
          // The issuing cycle is the first of MD_LAT stalled cycles.
          stall_c   = 1'b1;
          md_busy_c = 1'b1;
          md_cnt_d  = 4'(MD_LAT - 2);
          state_d   = MDBUSY;
        end else if (lu) begin
          stall_c      = 1'b1;
          flush_idex_c = 1'b1;
        end
      end
      MDBUSY: begin
        stall_c   = 1'b1;
        md_busy_c = 1'b1;
        if (md_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
      FLUSH2: begin
        flush_ifid_c = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs must read quiet while reset is held, regardless of inputs.
    if (reset) begin
      stall_c      = 1'b0;
      flush_ifid_c = 1'b0;
      flush_idex_c = 1'b0;
      md_busy_c    = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.flushIfid = flush_ifid_c;
  assign bus.flushIdex = flush_idex_c;
  assign bus.mdBusy    = md_busy_c;
  assign bus.stallCnt  = stall_cnt_q;

endmodule
